// File: rtl/rv_core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv_core_pkg: shared integer-core widths and the register write request. Rev 1.0
// ----------------------------------------------------------------------------
package rv_core_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wr_req_t;

  // x0 never owns a scoreboard bit, so its mask is always empty.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    reg_onehot = '0;
    if (a != '0) reg_onehot[a] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_write_arbiter_if: producer, issue, hazard-query and write-port bundle. Rev 1.0
// ----------------------------------------------------------------------------
interface regfile_write_arbiter_if;
  import rv_core_pkg::*;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_wd;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_wd;
  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [REG_AW-1:0] q_rs1;
  logic [REG_AW-1:0] q_rs2;
  logic [REG_AW-1:0] q_rd;
  logic              hazard;
  logic              we;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   wd;

  modport master (
    output ex_valid, ex_rd, ex_wd, lu_valid, lu_rd, lu_wd,
           iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
    input  lu_ready, hazard, we, rd, wd
  );

  modport slave (
    input  ex_valid, ex_rd, ex_wd, lu_valid, lu_rd, lu_wd,
           iss_valid, iss_rd, q_rs1, q_rs2, q_rd,
    output lu_ready, hazard, we, rd, wd
  );

endinterface
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_result_fifo: synchronous FIFO with wrap-bit pointers and a combinational head. Rev 1.0
// ----------------------------------------------------------------------------
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot on the same edge, so a full FIFO may still push.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_write_arbiter: merges execute and buffered long-latency results onto the write port. Rev 1.0
// ----------------------------------------------------------------------------
module regfile_write_arbiter
  import rv_core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  wr_req_t             w_lu_req;
  wr_req_t             w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_ex_wr;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                w_iss_conflict;
  logic                w_waw;

  assign w_lu_req.rd = bus.lu_rd;
  assign w_lu_req.wd = bus.lu_wd;

  // x0 results are acknowledged but never occupy a slot.
  assign w_push       = bus.lu_valid && !w_full && (bus.lu_rd != '0);
  assign bus.lu_ready = !w_full;
  assign w_ex_wr      = bus.ex_valid && (bus.ex_rd != '0);

  wb_result_fifo #(
    .WIDTH (XLEN + REG_AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_lu_req),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  always_comb begin
    bus.we = 1'b0;
    bus.rd = '0;
    bus.wd = '0;
    w_pop  = 1'b0;
    if (w_ex_wr) begin
      bus.we = 1'b1;
      bus.rd = bus.ex_rd;
      bus.wd = bus.ex_wd;
    end else if (!w_empty) begin
      bus.we = 1'b1;
      bus.rd = w_head.rd;
      bus.wd = w_head.wd;
      w_pop  = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    w_clr_mask = w_pop ? reg_onehot(w_head.rd) : '0;
    w_set_mask = bus.iss_valid ? reg_onehot(bus.iss_rd) : '0;
    pending_d  = (pending_q & ~w_clr_mask) | w_set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign bus.hazard = pending_q[bus.q_rs1] | pending_q[bus.q_rs2] | pending_q[bus.q_rd];

  assign w_iss_conflict = bus.iss_valid && (bus.iss_rd != '0) &&
                          pending_q[bus.iss_rd] && !w_clr_mask[bus.iss_rd];
  assign w_waw          = w_ex_wr && pending_q[bus.ex_rd];

  a_issue_to_pending: assert property (@(posedge clk) disable iff (!rst_n) !w_iss_conflict);
  a_ex_waw:           assert property (@(posedge clk) disable iff (!rst_n) !w_waw);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_write_arbiter: directed plan plus randomized traffic against a queue model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
  import rv_core_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [31:0]   m_pend = '0;
  wr_req_t       m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ex_valid  = 1'b0;  bus.ex_rd  = '0; bus.ex_wd = '0;
    bus.lu_valid  = 1'b0;  bus.lu_rd  = '0; bus.lu_wd = '0;
    bus.iss_valid = 1'b0;  bus.iss_rd = '0;
    bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
  endtask

  task automatic check_model();
    logic    ew;
    wr_req_t e;
    ew = 1'b0;
    e  = '0;
    if (bus.ex_valid && bus.ex_rd != '0) begin
      ew = 1'b1; e.rd = bus.ex_rd; e.wd = bus.ex_wd;
    end else if (m_q.size() > 0) begin
      ew = 1'b1; e = m_q[0];
    end
    chk("we",       64'(bus.we),       64'(ew));
    chk("rd",       64'(bus.rd),       64'(e.rd));
    chk("wd",       64'(bus.wd),       64'(e.wd));
    chk("lu_ready", 64'(bus.lu_ready), 64'(m_q.size() < DEPTH));
    chk("hazard",   64'(bus.hazard),
        64'(m_pend[bus.q_rs1] | m_pend[bus.q_rs2] | m_pend[bus.q_rd]));
  endtask

  task automatic advance();
    logic              ex_wr, pop, acc, iss;
    logic [REG_AW-1:0] iss_r;
    wr_req_t           pushed, hd;
    ex_wr     = bus.ex_valid && (bus.ex_rd != '0);
    pop       = !ex_wr && (m_q.size() > 0);
    acc       = bus.lu_valid && (m_q.size() < DEPTH) && (bus.lu_rd != '0);
    pushed.rd = bus.lu_rd;
    pushed.wd = bus.lu_wd;
    iss       = bus.iss_valid && (bus.iss_rd != '0);
    iss_r     = bus.iss_rd;
    @(posedge clk);
    if (pop) begin
      hd = m_q.pop_front();
      m_pend[hd.rd] = 1'b0;
    end
    if (acc) m_q.push_back(pushed);
    if (iss) m_pend[iss_r] = 1'b1;
    m_pend[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    #2;
    check_model();
    advance();
  endtask

  function automatic logic [REG_AW-1:0] pick_free();
    logic [REG_AW-1:0] r;
    for (int t = 0; t < 64; t++) begin
      r = REG_AW'($urandom_range(0, NUM_REGS - 1));
      if (!m_pend[r]) return r;
    end
    return '0;
  endfunction

  function automatic logic [REG_AW-1:0] pick_any_bias_pending();
    logic [REG_AW-1:0] r;
    if ($urandom_range(0, 1) == 0) begin
      for (int t = 0; t < 64; t++) begin
        r = REG_AW'($urandom_range(1, NUM_REGS - 1));
        if (m_pend[r]) return r;
      end
    end
    return REG_AW'($urandom_range(0, NUM_REGS - 1));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);

    // Outputs during reset follow the execute inputs only.
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_wd = 32'hA5A5_0003;
    #2;
    chk("rst_we",       64'(bus.we),       64'd1);
    chk("rst_rd",       64'(bus.rd),       64'd3);
    chk("rst_lu_ready", 64'(bus.lu_ready), 64'd1);
    chk("rst_hazard",   64'(bus.hazard),   64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Execute write lands in the same cycle.
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_wd = 32'hDEAD_BEEF;
    #2;
    chk("t1_we",       64'(bus.we),       64'd1);
    chk("t1_rd",       64'(bus.rd),       64'd5);
    chk("t1_wd",       64'(bus.wd),       64'hDEAD_BEEF);
    chk("t1_lu_ready", 64'(bus.lu_ready), 64'd1);
    check_model(); advance();

    // Issue x7, then its result retires one cycle after acceptance.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; step();
    idle(); bus.q_rs1 = 5'd7;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_wd = 32'h1234;
    #2;
    chk("t2_hazard_set", 64'(bus.hazard), 64'd1);
    chk("t2_we_idle",    64'(bus.we),     64'd0);
    check_model(); advance();
    idle(); bus.q_rs1 = 5'd7;
    #2;
    chk("t2_we", 64'(bus.we), 64'd1);
    chk("t2_rd", 64'(bus.rd), 64'd7);
    chk("t2_wd", 64'(bus.wd), 64'h1234);
    check_model(); advance();
    idle(); bus.q_rs1 = 5'd7;
    #2;
    chk("t2_hazard_clr", 64'(bus.hazard), 64'd0);
    check_model(); advance();

    // Execute stream holds the FIFO; third offer stalls.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd8; step();
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9; step();
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.ex_valid = 1'b1; bus.ex_rd = REG_AW'(3 + i); bus.ex_wd = 32'(100 + i);
      bus.lu_valid = 1'b1;
      bus.lu_rd    = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd10;
      bus.lu_wd    = 32'hA000 + 32'(bus.lu_rd);
      #2;
      chk("t3_lu_ready", 64'(bus.lu_ready), 64'(i < 2));
      chk("t3_ex_rd",    64'(bus.rd),       64'(3 + i));
      check_model(); advance();
    end
    idle();
    #2;
    chk("t3_first_rd", 64'(bus.rd), 64'd8);
    check_model(); advance();
    idle();
    #2;
    chk("t3_second_rd", 64'(bus.rd), 64'd9);
    chk("t3_second_wd", 64'(bus.wd), 64'hA009);
    check_model(); advance();

    // Execute write to x0 leaves the port to the FIFO.
    idle(); bus.lu_valid = 1'b1; bus.lu_rd = 5'd10; bus.lu_wd = 32'h55; step();
    idle(); bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_wd = 32'hFFFF_FFFF;
    #2;
    chk("t4_we", 64'(bus.we), 64'd1);
    chk("t4_rd", 64'(bus.rd), 64'd10);
    chk("t4_wd", 64'(bus.wd), 64'h55);
    check_model(); advance();

    // Reissue of x12 on the cycle its result retires keeps the bit set.
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd12; step();
    idle(); bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_wd = 32'hC12; step();
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    #2;
    chk("t5_rd", 64'(bus.rd), 64'd12);
    check_model(); advance();
    idle(); bus.q_rd = 5'd12;
    #2;
    chk("t5_hazard", 64'(bus.hazard), 64'd1);
    check_model(); advance();
    idle(); bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_wd = 32'hC13; step();
    idle(); step();

    // Reset mid-operation with two buffered results and three pending bits.
    for (int i = 0; i < 3; i++) begin
      idle(); bus.iss_valid = 1'b1; bus.iss_rd = REG_AW'(20 + i); step();
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd1; bus.ex_wd = 32'(i);
      bus.lu_valid = 1'b1; bus.lu_rd = REG_AW'(20 + i); bus.lu_wd = 32'hB00 + 32'(i);
      step();
    end
    idle(); bus.q_rs1 = 5'd20; bus.q_rs2 = 5'd21; bus.q_rd = 5'd22;
    #1;
    chk("t6_pre_hazard",   64'(bus.hazard),   64'd1);
    chk("t6_pre_lu_ready", 64'(bus.lu_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_lu_ready", 64'(bus.lu_ready), 64'd1);
    chk("t6_rst_hazard",   64'(bus.hazard),   64'd0);
    chk("t6_rst_we",       64'(bus.we),       64'd0);
    m_q.delete();
    m_pend = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(); bus.q_rs1 = 5'd20; bus.q_rs2 = 5'd21; bus.q_rd = 5'd22;
      #2;
      chk("t6_post_we", 64'(bus.we), 64'd0);
      check_model(); advance();
    end

    // Randomized traffic against the queue/scoreboard model.
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.ex_valid = ($urandom_range(0, 1) == 1);
      bus.ex_rd    = ($urandom_range(0, 7) == 0) ? '0 : pick_free();
      bus.ex_wd    = $urandom;
      bus.lu_valid = ($urandom_range(0, 2) != 0);
      bus.lu_rd    = pick_any_bias_pending();
      bus.lu_wd    = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        bus.iss_valid = 1'b1;
        bus.iss_rd    = pick_free();
      end
      bus.q_rs1 = REG_AW'($urandom_range(0, NUM_REGS - 1));
      bus.q_rs2 = REG_AW'($urandom_range(0, NUM_REGS - 1));
      bus.q_rd  = REG_AW'($urandom_range(0, NUM_REGS - 1));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
